scaler_sequencer: RTL and testbench

//   Top-level sequencer for the image-scaling engines (replication, decimation, nearest, average).
//   On a start request it clears the 320x240 frame RAM, resets and launches the engine chosen by

---
 rtl/scaler_sequencer.sv | 179 +++++++++++++++++
 tb/tb_scaler_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scaler_sequencer : clears the frame RAM, launches the selected scaling engine
//                    and muxes its ROM/RAM buses onto the shared memories.
// Revision 1.0
// ---------------------------------------------------------------------------
module scaler_sequencer #(
  parameter int                ADDR_W     = 19,
  parameter int                DATA_W     = 8,
  parameter int                RAM_WORDS  = 76800,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int                RST_CYCLES = 2,
  parameter int                TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            seletor,
  input  logic [4*ADDR_W-1:0]   eng_rom_addr,
  input  logic [4*ADDR_W-1:0]   eng_wraddr,
  input  logic [4*DATA_W-1:0]   eng_wdata,
  input  logic [3:0]            eng_wren,
  input  logic [3:0]            eng_done,
  output logic [3:0]            eng_rst,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic [ADDR_W-1:0]     ram_wraddr,
  output logic [DATA_W-1:0]     ram_data,
  output logic                  ram_wren,
  output logic [1:0]            active_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CLR_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LCH_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RAM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LCH_W-1:0] LCH_LAST = LCH_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [LCH_W-1:0]    lch_cnt_q, lch_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0]   ram_wraddr_q, ram_wraddr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic                launch;

  logic [ADDR_W-1:0]   rom_addr_a [4];
  logic [ADDR_W-1:0]   wraddr_a   [4];
  logic [DATA_W-1:0]   wdata_a    [4];

  genvar k;
  for (k = 0; k < 4; k++) begin : g_unpack
    assign rom_addr_a[k] = eng_rom_addr[k*ADDR_W +: ADDR_W];
    assign wraddr_a[k]   = eng_wraddr[k*ADDR_W +: ADDR_W];
    assign wdata_a[k]    = eng_wdata[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'b00;
      clr_cnt_q    <= '0;
      lch_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      ram_wraddr_q <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      clr_cnt_q    <= clr_cnt_d;
      lch_cnt_q    <= lch_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    clr_cnt_d    = clr_cnt_q;
    lch_cnt_d    = lch_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ram_wraddr_d = ram_wraddr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    launch       = 1'b0;

    unique case (state_q)
      S_IDLE: launch = start;

      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_LAUNCH;
        end else begin
          clr_cnt_d    = clr_cnt_q + 1'b1;
          ram_wraddr_d = ADDR_W'(clr_cnt_d);
          ram_data_d   = CLEAR_VAL;
          ram_wren_d   = 1'b1;
        end
      end

      S_LAUNCH: begin
        if (lch_cnt_q == LCH_LAST) begin
          state_d   = S_RUN;
          tmo_cnt_d = '0;
        end else begin
          lch_cnt_d = lch_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Capture the engine write every cycle, including the one that sees done,
        // so DRAIN forwards the final write.
        ram_wraddr_d = wraddr_a[sel_q];
        ram_data_d   = wdata_a[sel_q];
        ram_wren_d   = eng_wren[sel_q];
        if (eng_done[sel_q]) begin
          state_d = S_DRAIN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_DRAIN: state_d = S_DONE;

      S_DONE:  launch = start || (seletor != sel_q);

      S_ERROR: launch = start;

      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d      = S_CLEAR;
      sel_d        = seletor;
      clr_cnt_d    = '0;
      lch_cnt_d    = '0;
      tmo_cnt_d    = '0;
      ram_wraddr_d = '0;
      ram_data_d   = CLEAR_VAL;
      ram_wren_d   = 1'b1;
    end
  end

  // ROM address bypasses the register so engine ROM latency is unaffected.
  assign rom_addr   = (state_q == S_RUN) ? rom_addr_a[sel_q] : '0;
  assign eng_rst    = (state_q == S_RUN) ? ~(4'b0001 << sel_q) : 4'b1111;
  assign ram_wraddr = ram_wraddr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;
  assign active_sel = sel_q;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_LAUNCH) ||
                      (state_q == S_RUN)   || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_scaler_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scaler_sequencer : directed stimulus, phase/age reference model and
//                       literal checks for scaler_sequencer. Revision 1.0
// ---------------------------------------------------------------------------
module tb_scaler_sequencer;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int RAM_WORDS = 16;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT = 32;
  localparam logic [DW-1:0] CLR_V = 8'h00;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_LAUNCH = 2, P_RUN = 3,
                 P_DRAIN = 4, P_DONE = 5, P_ERROR = 6;

  logic              clk, reset, start;
  logic [1:0]        seletor;
  logic [4*AW-1:0]   eng_rom_addr, eng_wraddr;
  logic [4*DW-1:0]   eng_wdata;
  logic [3:0]        eng_wren, eng_done;
  logic [3:0]        eng_rst;
  logic [AW-1:0]     rom_addr, ram_wraddr;
  logic [DW-1:0]     ram_data;
  logic              ram_wren;
  logic [1:0]        active_sel;
  logic              busy, done, err;

  scaler_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_WORDS(RAM_WORDS), .CLEAR_VAL(CLR_V),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seletor(seletor),
    .eng_rom_addr(eng_rom_addr), .eng_wraddr(eng_wraddr), .eng_wdata(eng_wdata),
    .eng_wren(eng_wren), .eng_done(eng_done), .eng_rst(eng_rst),
    .rom_addr(rom_addr), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
    .ram_wren(ram_wren), .active_sel(active_sel), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit chk_rom3 = 1'b0;

  // Reference model: current phase, cycles spent in it, and the write shown on the RAM bus.
  int             m_phase = P_IDLE;
  int             m_age   = 0;
  logic [1:0]     m_sel   = 2'b00;
  logic [AW-1:0]  m_cap_wa = '0, m_hold_wa = '0;
  logic [DW-1:0]  m_cap_wd = '0, m_hold_wd = '0;
  logic           m_cap_we = 1'b0;

  function automatic logic [AW-1:0] pat_ra(input int k, input int c);
    return AW'(k * 20000 + c * 7);
  endfunction
  function automatic logic [AW-1:0] pat_wa(input int k, input int c);
    return AW'(k * 1000 + c);
  endfunction
  function automatic logic [DW-1:0] pat_wd(input int k, input int c);
    return DW'(k * 64 + c);
  endfunction
  function automatic logic pat_we(input int k, input int c);
    return ((c + k) % 3) == 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int nxt;
    bit go;
    nxt = m_phase;
    go  = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_age = 0; m_sel = 2'b00;
      m_hold_wa = '0; m_hold_wd = '0;
      m_cap_wa = '0; m_cap_wd = '0; m_cap_we = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:  go = start;
        P_CLEAR: if (m_age == RAM_WORDS - 1) begin
          nxt = P_LAUNCH;
          m_hold_wa = AW'(RAM_WORDS - 1);
          m_hold_wd = CLR_V;
        end
        P_LAUNCH: if (m_age == RST_CYCLES - 1) nxt = P_RUN;
        P_RUN: begin
          m_cap_wa = eng_wraddr[m_sel*AW +: AW];
          m_cap_wd = eng_wdata[m_sel*DW +: DW];
          m_cap_we = eng_wren[m_sel];
          m_hold_wa = m_cap_wa;
          m_hold_wd = m_cap_wd;
          if (eng_done[m_sel]) nxt = P_DRAIN;
          else if (m_age == TIMEOUT - 1) nxt = P_ERROR;
        end
        P_DRAIN: nxt = P_DONE;
        P_DONE:  go = start || (seletor != m_sel);
        P_ERROR: go = start;
        default: nxt = P_IDLE;
      endcase
      if (go) begin
        nxt = P_CLEAR;
        m_sel = seletor;
      end
      if (go || nxt != m_phase) m_age = 0;
      else m_age++;
      m_phase = nxt;
    end
  endtask

  task automatic compare();
    logic [3:0]    e_rst;
    logic [AW-1:0] e_rom, e_wa;
    logic [DW-1:0] e_wd;
    logic          e_we;
    bit            in_run;
    in_run = (m_phase == P_RUN);
    e_rst  = in_run ? ~(4'b0001 << m_sel) : 4'b1111;
    e_rom  = in_run ? eng_rom_addr[m_sel*AW +: AW] : '0;
    if (m_phase == P_CLEAR) begin
      e_wa = AW'(m_age); e_wd = CLR_V; e_we = 1'b1;
    end else if ((in_run && m_age > 0) || m_phase == P_DRAIN) begin
      e_wa = m_cap_wa; e_wd = m_cap_wd; e_we = m_cap_we;
    end else begin
      e_wa = m_hold_wa; e_wd = m_hold_wd; e_we = 1'b0;
    end
    chk("m_eng_rst", eng_rst, e_rst);
    chk("m_rom_addr", rom_addr, e_rom);
    chk("m_ram_wraddr", ram_wraddr, e_wa);
    chk("m_ram_data", ram_data, e_wd);
    chk("m_ram_wren", ram_wren, e_we);
    chk("m_active_sel", active_sel, m_sel);
    chk("m_busy", busy, (m_phase >= P_CLEAR && m_phase <= P_DRAIN));
    chk("m_done", done, m_phase == P_DONE);
    chk("m_err", err, m_phase == P_ERROR);
  endtask

  // One clock: drive engine buses, check mid-cycle, advance model at the edge.
  task automatic tick();
    for (int k = 0; k < 4; k++) begin
      eng_rom_addr[k*AW +: AW] = pat_ra(k, cyc);
      eng_wraddr[k*AW +: AW]   = pat_wa(k, cyc);
      eng_wdata[k*DW +: DW]    = pat_wd(k, cyc);
      eng_wren[k]              = pat_we(k, cyc);
    end
    #1;
    if (chk_en) compare();
    if (chk_rom3) chk("rom_addr_eng3", rom_addr, pat_ra(3, cyc));
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seletor = 2'b00; eng_done = 4'b0000;
    eng_rom_addr = '0; eng_wraddr = '0; eng_wdata = '0; eng_wren = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_eng_rst", eng_rst, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_sel", active_sel, 2'b00);

    // Basic run on engine 0
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_addr", ram_wraddr, 0);
    chk("clr_wren", ram_wren, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("clr_addr", ram_wraddr, i);
      chk("clr_data", ram_data, 8'h00);
    end
    tick();
    chk("launch_rst_a", eng_rst, 4'b1111);
    chk("launch_wren", ram_wren, 1'b0);
    tick();
    chk("launch_rst_b", eng_rst, 4'b1111);
    tick();
    chk("run_rst0", eng_rst, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("eng0_lat_addr", ram_wraddr, pat_wa(0, cyc - 1));
      chk("eng0_lat_wren", ram_wren, pat_we(0, cyc - 1));
    end
    eng_done = 4'b0001; tick();
    chk("drain_busy", busy, 1'b1);
    chk("drain_done", done, 1'b0);
    tick();
    chk("done0", done, 1'b1);
    eng_done = 4'b0000;

    // Auto-switch from DONE on a seletor change
    tick();
    chk("done_hold", done, 1'b1);
    seletor = 2'b01; tick();
    chk("auto_busy", busy, 1'b1);
    chk("auto_sel", active_sel, 2'b01);
    repeat (18) tick();
    chk("run_rst1", eng_rst, 4'b1101);

    // start and seletor changes during RUN are ignored
    start = 1'b1; seletor = 2'b10;
    repeat (3) tick();
    chk("ign_sel", active_sel, 2'b01);
    chk("ign_busy", busy, 1'b1);
    chk("ign_rst", eng_rst, 4'b1101);
    start = 1'b0; seletor = 2'b01;
    repeat (2) tick();
    eng_done = 4'b0010; tick(); tick();
    chk("done1", done, 1'b1);
    chk("done1_sel", active_sel, 2'b01);

    // Watchdog timeout on engine 2
    eng_done = 4'b0000; seletor = 2'b10; start = 1'b1; tick(); start = 1'b0;
    repeat (18) tick();
    chk("run_rst2", eng_rst, 4'b1011);
    repeat (31) tick();
    chk("tmo_not_yet", err, 1'b0);
    chk("tmo_busy", busy, 1'b1);
    tick();
    chk("tmo_err", err, 1'b1);
    chk("tmo_idle_bus", busy, 1'b0);
    chk("tmo_wren", ram_wren, 1'b0);
    tick();
    chk("tmo_err_hold", err, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun_err_clr", err, 1'b0);
    chk("rerun_busy", busy, 1'b1);

    // Done arrives in the same cycle the watchdog expires
    repeat (18) tick();
    repeat (31) tick();
    eng_done = 4'b0100; tick();
    chk("race_drain_err", err, 1'b0);
    chk("race_drain_busy", busy, 1'b1);
    tick();
    chk("race_done", done, 1'b1);
    chk("race_err", err, 1'b0);
    eng_done = 4'b0000;

    // Reset in the middle of CLEAR
    seletor = 2'b11; start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("clr7_addr", ram_wraddr, 7);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_wren", ram_wren, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sel", active_sel, 2'b00);
    chk("mid_rst_eng", eng_rst, 4'b1111);
    chk("mid_rst_addr", ram_wraddr, 0);
    tick();
    chk("mid_rst_idle", busy, 1'b0);

    // Engine 3: combinational ROM path and write isolation
    start = 1'b1; tick(); start = 1'b0;
    repeat (18) tick();
    chk("run_rst3", eng_rst, 4'b0111);
    chk_rom3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("eng3_addr", ram_wraddr, pat_wa(3, cyc - 1));
      chk("eng3_wren", ram_wren, pat_we(3, cyc - 1));
    end
    chk_rom3 = 1'b0;
    eng_done = 4'b1000; tick();
    chk("drain3_addr", ram_wraddr, pat_wa(3, cyc - 1));
    chk("drain3_data", ram_data, pat_wd(3, cyc - 1));
    tick();
    chk("done3", done, 1'b1);
    eng_done = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
